// File: rtl/reward_spawner_if.sv
// Signal bundle between the game FSM / overlay side (master) and the reward spawner (slave).
interface reward_spawner_if;
  logic       game_run;
  logic       tick;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [5:0] food_x;
  logic [5:0] food_y;
  logic       set_require;
  logic       enable_reward;
  logic [5:0] random_xpos;
  logic [5:0] random_ypos;
  logic [1:0] reward_type;
  logic       reward_hit;
  logic [1:0] reward_hit_type;

  modport master (
    output game_run, tick, head_x, head_y, food_x, food_y,
    input  set_require, enable_reward, random_xpos, random_ypos, reward_type,
    input  reward_hit, reward_hit_type
  );

  modport slave (
    input  game_run, tick, head_x, head_y, food_x, food_y,
    output set_require, enable_reward, random_xpos, random_ypos, reward_type,
    output reward_hit, reward_hit_type
  );
endinterface

// File: rtl/reward_spawner.sv
// Reward spawner: waits, places a reward on a free grid cell from an LFSR, blinks it near the end
// of its lifetime and reports when the snake head collects it.
module reward_spawner #(
  parameter int unsigned GRID_W      = 28,
  parameter int unsigned GRID_H      = 18,
  parameter int unsigned DELAY_TICKS = 40,
  parameter int unsigned LIFE_TICKS  = 60,
  parameter int unsigned BLINK_TICKS = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  reward_spawner_if.slave  rs_io
);

  localparam int unsigned MaxTicks  = (DELAY_TICKS > LIFE_TICKS) ? DELAY_TICKS : LIFE_TICKS;
  localparam int unsigned CntW      = $clog2(MaxTicks) + 1;
  localparam logic [CntW-1:0] DelayLast = CntW'(DELAY_TICKS - 1);
  localparam logic [CntW-1:0] LifeLast  = CntW'(LIFE_TICKS - 1);
  // Last count value before blinking begins; a tick at or beyond it toggles visibility.
  localparam logic [CntW-1:0] BlinkLast = CntW'(LIFE_TICKS - BLINK_TICKS - 1);
  localparam logic [6:0]      GridW7    = 7'(GRID_W);
  localparam logic [6:0]      GridH7    = 7'(GRID_H);

  typedef enum logic [1:0] {StIdle, StWait, StPlace, StActive} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [5:0]      xpos_q, xpos_d;
  logic [5:0]      ypos_q, ypos_d;
  logic [1:0]      type_q, type_d;
  logic            enable_q, enable_d;
  logic            hit_q, hit_d;
  logic [1:0]      hit_type_q, hit_type_d;

  logic [5:0] cand_x, cand_y;
  logic [1:0] cand_t;
  logic       cand_ok, head_match, lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cand_x  = lfsr_q[5:0];
  assign cand_y  = lfsr_q[11:6];
  assign cand_t  = lfsr_q[13:12];

  assign cand_ok = ({1'b0, cand_x} < GridW7) && ({1'b0, cand_y} < GridH7) &&
                   (cand_t != 2'b00) &&
                   !((cand_x == rs_io.food_x) && (cand_y == rs_io.food_y)) &&
                   !((cand_x == rs_io.head_x) && (cand_y == rs_io.head_y));

  assign head_match = (rs_io.head_x == xpos_q) && (rs_io.head_y == ypos_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_fb};
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    type_d     = type_q;
    enable_d   = enable_q;
    hit_d      = 1'b0;
    hit_type_d = hit_type_q;

    if (!rs_io.game_run) begin
      state_d  = StIdle;
      cnt_d    = '0;
      xpos_d   = '0;
      ypos_d   = '0;
      type_d   = '0;
      enable_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWait;
          cnt_d   = '0;
        end
        StWait: begin
          if (rs_io.tick) begin
            if (cnt_q == DelayLast) begin
              state_d = StPlace;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StPlace: begin
          if (cand_ok) begin
            state_d  = StActive;
            cnt_d    = '0;
            xpos_d   = cand_x;
            ypos_d   = cand_y;
            type_d   = cand_t;
            enable_d = 1'b1;
          end
        end
        StActive: begin
          // A hit takes priority over expiry on the same cycle.
          if (head_match) begin
            hit_d      = 1'b1;
            hit_type_d = type_q;
            state_d    = StWait;
            cnt_d      = '0;
            xpos_d     = '0;
            ypos_d     = '0;
            type_d     = '0;
            enable_d   = 1'b0;
          end else if (rs_io.tick) begin
            if (cnt_q == LifeLast) begin
              state_d  = StWait;
              cnt_d    = '0;
              xpos_d   = '0;
              ypos_d   = '0;
              type_d   = '0;
              enable_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_q >= BlinkLast) enable_d = ~enable_q;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      xpos_q     <= '0;
      ypos_q     <= '0;
      type_q     <= '0;
      enable_q   <= 1'b0;
      hit_q      <= 1'b0;
      hit_type_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      type_q     <= type_d;
      enable_q   <= enable_d;
      hit_q      <= hit_d;
      hit_type_q <= hit_type_d;
    end
  end

  assign rs_io.set_require     = (state_q == StActive);
  assign rs_io.enable_reward   = enable_q;
  assign rs_io.random_xpos     = xpos_q;
  assign rs_io.random_ypos     = ypos_q;
  assign rs_io.reward_type     = type_q;
  assign rs_io.reward_hit      = hit_q;
  assign rs_io.reward_hit_type = hit_type_q;

endmodule
